// File: rtl/bit_serializer.sv
// bit_serializer
//   Upstream stage of the serial sequence detector. Parallel words arrive over
//   a valid/ready handshake and leave one bit per clock on a registered serial
//   line. A one-word holding register lets back-to-back words stream with no
//   idle gap. With no word pending, the line sits at IDLE_BIT.
//
//   Parameters
//     WIDTH      bits per word (must be at least 2)
//     MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//     IDLE_BIT   level on ser_out while ser_valid is low
//
//   Ports
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     in_data    parallel word, sampled only on acceptance
//     in_valid   in_data is valid
//     in_ready   a word can be accepted this cycle (registered state only)
//     ser_out    serial bit, drives the detector's data_in
//     ser_valid  ser_out carries a word bit this cycle
//     word_done  last bit of a word is on ser_out
//     busy       shift or holding register occupied
//
//   state | meaning
//   IDLE  | line at IDLE_BIT, waiting for a word
//   SHIFT | a word bit is on ser_out, cnt_q is its index within the word
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hr_q, hr_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             accept;

  // First bit of a word in transmit order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // SR keeps only the bits not yet on the line; the next one to leave always
  // sits where first_bit() looks for it.
  function automatic logic [WIDTH-1:0] remaining(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign in_ready = !hold_full_q;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      hr_q        <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      ser_out_q   <= IDLE_BIT;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      hr_q        <= hr_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    hr_d        = hr_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    ser_out_d   = ser_out_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SHIFT;
          ser_out_d = first_bit(in_data);
          sr_d      = remaining(in_data);
          cnt_d     = '0;
        end
      end

      SHIFT: begin
        if (cnt_q != LAST) begin
          ser_out_d = first_bit(sr_q);
          sr_d      = remaining(sr_q);
          cnt_d     = cnt_q + CW'(1);
          if (accept) begin
            hr_d        = in_data;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // in_ready is low here, so no accept can collide with the reload.
          ser_out_d   = first_bit(hr_q);
          sr_d        = remaining(hr_q);
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          ser_out_d = first_bit(in_data);
          sr_d      = remaining(in_data);
          cnt_d     = '0;
        end else begin
          state_d   = IDLE;
          ser_out_d = IDLE_BIT;
          cnt_d     = '0;
        end
      end

      default: begin
        state_d   = IDLE;
        ser_out_d = IDLE_BIT;
        cnt_d     = '0;
      end
    endcase
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = (state_q == SHIFT);
  assign word_done = ser_valid && (cnt_q == LAST);
  assign busy      = ser_valid || hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // a: WIDTH=8 MSB first idle 0; b: WIDTH=8 LSB first; c: WIDTH=4 idle 1
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_so, a_sv, a_done, a_busy;
  logic [7:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_so, b_sv, b_done, b_busy;
  logic [3:0] c_data = '0;
  logic       c_valid = 1'b0;
  logic       c_ready, c_so, c_sv, c_done, c_busy;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .ser_out(a_so), .ser_valid(a_sv),
    .word_done(a_done), .busy(a_busy));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .ser_out(b_so), .ser_valid(b_sv),
    .word_done(b_done), .busy(b_busy));

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid),
    .in_ready(c_ready), .ser_out(c_so), .ser_valid(c_sv),
    .word_done(c_done), .busy(c_busy));

  // Reference 101 detector fed by the LSB-first serializer.
  logic [1:0] det_hist;
  logic       det;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_hist <= '0;
      det      <= 1'b0;
    end else begin
      det_hist <= {det_hist[0], b_so};
      det      <= ({det_hist, b_so} == 3'b101);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0]  w8;
    logic [15:0] s16;
    logic [23:0] s24, got24;
    logic [7:0]  words [3];
    logic [3:0]  w4;
    int idx, nbits, gaps, stall_seen, stray, det_cnt, det_pos;
    logic acc, started;

    // reset state
    #12;
    check_val("rst_ser_out", a_so, 0);
    check_val("rst_ser_valid", a_sv, 0);
    check_val("rst_word_done", a_done, 0);
    check_val("rst_busy", a_busy, 0);
    check_val("rst_in_ready", a_ready, 1);
    check_val("rst_c_idle", c_so, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single word 8'hA0
    @(negedge clk);
    w8 = 8'hA0;
    a_data = w8; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("t1_valid%0d", i), a_sv, 1);
      check_val($sformatf("t1_bit%0d", i), a_so, w8[7-i]);
      check_val($sformatf("t1_done%0d", i), a_done, (i == 7));
      @(negedge clk);
    end
    check_val("t1_valid_after", a_sv, 0);
    check_val("t1_idle_after", a_so, 0);
    check_val("t1_busy_after", a_busy, 0);

    // 2: back-to-back A5, 3C
    @(negedge clk);
    s16 = 16'hA53C;
    a_data = 8'hA5; a_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      check_val($sformatf("t2_valid%0d", i), a_sv, 1);
      check_val($sformatf("t2_bit%0d", i), a_so, s16[15-i]);
      check_val($sformatf("t2_done%0d", i), a_done, (i == 7 || i == 15));
      check_val($sformatf("t2_ready%0d", i), a_ready, (i == 0 || i >= 8));
      if (i == 0) a_data = 8'h3C;
      if (i == 1) a_valid = 1'b0;
      @(negedge clk);
    end
    check_val("t2_valid_after", a_sv, 0);
    check_val("t2_busy_after", a_busy, 0);

    // 3: three words offered continuously, third one stalls
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    s24 = {8'h01, 8'h02, 8'h03};
    got24 = '0;
    idx = 0; nbits = 0; gaps = 0; stall_seen = 0; started = 1'b0;
    @(negedge clk);
    a_data = words[0]; a_valid = 1'b1;
    for (int cyc = 0; cyc < 32; cyc++) begin
      acc = a_valid && a_ready;
      if (a_valid && !a_ready && idx == 2) stall_seen = 1;
      @(negedge clk);
      if (acc) idx++;
      if (a_sv) begin
        if (nbits < 24) got24[23-nbits] = a_so;
        nbits++;
        started = 1'b1;
      end else if (started && nbits < 24) begin
        gaps++;
      end
      if (idx < 3) begin
        a_valid = 1'b1;
        a_data  = words[idx];
      end else begin
        a_valid = 1'b0;
      end
    end
    check_val("t3_accepted", idx, 3);
    check_val("t3_stall_seen", stall_seen, 1);
    check_val("t3_nbits", nbits, 24);
    check_val("t3_gaps", gaps, 0);
    check_val("t3_stream", got24, s24);

    // 4: reset after the 3rd bit of 8'hFF
    @(negedge clk);
    a_data = 8'hFF; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("t4_bit3_valid", a_sv, 1);
    check_val("t4_bit3", a_so, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t4_rst_valid", a_sv, 0);
    check_val("t4_rst_ser_out", a_so, 0);
    check_val("t4_rst_busy", a_busy, 0);
    check_val("t4_rst_ready", a_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_sv || a_so || a_busy) stray++;
    end
    check_val("t4_stray", stray, 0);
    a_data = 8'h81; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    check_val("t4_recover_valid", a_sv, 1);
    check_val("t4_recover_bit", a_so, 1);
    for (int i = 0; i < 8; i++) @(negedge clk);

    // 5: LSB first 8'h05 into the 101 detector
    w8 = 8'h05;
    det_cnt = 0; det_pos = -1;
    b_data = w8; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        check_val($sformatf("t5_valid%0d", i), b_sv, 1);
        check_val($sformatf("t5_bit%0d", i), b_so, w8[i]);
      end
      if (det) begin
        det_cnt++;
        det_pos = i;
      end
      @(negedge clk);
    end
    check_val("t5_valid_after", b_sv, 0);
    check_val("t5_det_count", det_cnt, 1);
    check_val("t5_det_pos", det_pos, 3);

    // 6: idle level 1, WIDTH=4, word 4'b0000
    check_val("t6_idle_before", c_so, 1);
    check_val("t6_valid_before", c_sv, 0);
    w4 = 4'b0000;
    c_data = w4; c_valid = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t6_valid%0d", i), c_sv, 1);
      check_val($sformatf("t6_bit%0d", i), c_so, w4[3-i]);
      check_val($sformatf("t6_done%0d", i), c_done, (i == 3));
      @(negedge clk);
    end
    check_val("t6_idle_after", c_so, 1);
    check_val("t6_valid_after", c_sv, 0);
    check_val("t6_busy_after", c_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Upstream stage of the serial sequence detector. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a registered serial line, which drives the detector's `data_in`. A one-word holding register lets back-to-back words stream with no idle gap. When no word is pending, the line drives a fixed idle level.

Parameters:
- WIDTH, 8: bits per word. Must be at least 2.
- MSB_FIRST, 1: 1 shifts out bit WIDTH-1 first; 0 shifts out bit 0 first.
- IDLE_BIT, 0: level driven on ser_out while ser_valid=0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  parallel word to serialize.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- ser_out  out  1  serial bit; connects to the detector's data_in.
- ser_valid  out  1  ser_out carries a word bit this cycle.
- word_done  out  1  high while the last bit of a word is on ser_out.
- busy  out  1  shift register or holding register occupied.

Behaviour:
- Reset (async, rst_n=0):
  - ser_out=IDLE_BIT, ser_valid=0, word_done=0, busy=0, in_ready=1.
  - Bit counter=0, holding register empty, state=IDLE.
  - Any partial word and any held word are discarded.
  - Release is synchronous to the next clk edge.
- Storage:
  - Shift register SR (WIDTH bits) and bit counter CNT (range 0..WIDTH-1, width clog2(WIDTH)).
  - Holding register HR with flag hold_full.
- Handshake:
  - in_ready = !hold_full. This is a combinational function of registered state only; it never depends on in_valid.
  - A word is accepted on a rising edge where in_valid && in_ready.
  - in_data is sampled only at acceptance.
  - The block never drops an accepted word.
- States: IDLE and SHIFT.
- IDLE:
  - On accept, load the word into SR; next state SHIFT.
  - On that same edge, ser_out is set to the word's first bit, ser_valid=1, and CNT=0.
  - Latency: the first bit is visible in the cycle immediately after the accepting edge.
- SHIFT, each edge:
  - If CNT < WIDTH-1: advance to the next bit and CNT+1.
  - If CNT == WIDTH-1 (last bit on the line), the word finishes on this edge. Then, in priority order:
    - (a) If hold_full: move HR into SR, clear hold_full, present its first bit, CNT=0, stay in SHIFT.
    - (b) Else if an accept occurs on this edge: load the new word straight into SR, present its first bit, CNT=0, stay in SHIFT.
    - (c) Else: ser_valid=0, ser_out=IDLE_BIT, go to IDLE.
  - An accept in SHIFT that is not consumed by case (b) writes HR and sets hold_full.
  - Case (a) and an accept cannot coincide, because in_ready=0 while hold_full.
- Outputs:
  - word_done = ser_valid && (CNT == WIDTH-1).
  - busy = ser_valid || hold_full.
- Throughput: continuous in_valid gives a gap-free bit stream. ser_valid stays high for N*WIDTH consecutive cycles for N words.
- Bit order: MSB_FIRST=1 emits in_data[WIDTH-1] down to [0]; MSB_FIRST=0 emits [0] up to [WIDTH-1].
- Reset asserted mid-word: outputs go to reset values immediately (asynchronously). No remaining bits are emitted after release.

Test Plan:
1. Single word, WIDTH=8, MSB_FIRST=1, in_data=8'hA0, one-cycle in_valid from IDLE:
   - ser_out = 1,0,1,0,0,0,0,0 starting the cycle after acceptance.
   - ser_valid high for exactly 8 cycles; word_done high only on the 8th.
   - ser_out returns to 0 afterwards.
2. Back-to-back, words 8'hA5 then 8'h3C, in_valid held high:
   - 16 contiguous valid bits 10100101 00111100.
   - in_ready low from the edge after the second acceptance until the first word's last bit leaves.
   - word_done high on cycles 8 and 16.
3. Handshake stall, three words 8'h01, 8'h02, 8'h03 offered continuously:
   - The third word is held off (in_ready=0) until HR frees.
   - All 24 bits appear in order with no loss and no duplicates.
4. Reset mid-word: send 8'hFF, assert rst_n=0 after the 3rd bit.
   - ser_valid=0 and ser_out=0 immediately; busy=0, in_ready=1.
   - After release, no stray bits until a new word is accepted.
5. LSB first (MSB_FIRST=0), in_data=8'h05:
   - ser_out = 1,0,1,0,0,0,0,0.
   - When chained into the 101 detector, sequence_detected pulses exactly once, one cycle after the third bit is sampled.
6. Idle level (IDLE_BIT=1), WIDTH=4, in_data=4'b0000:
   - ser_out=1 before and after the word, 0 for exactly 4 valid cycles.
